// File: rtl/mult_div_unit.sv
// Multi-cycle MIPS multiply/divide unit owning HI/LO; result computed at the start edge, committed after MULT_CYCLES/DIV_CYCLES.
// busy is high for exactly N cycles; starts arriving while busy are dropped, so the hazard unit must hold them off.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDUOut
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   thi_q, thi_d, tlo_q, tlo_d;
  logic          commit_q, commit_d;

  logic [63:0] prod_s, prod_u;
  logic        b_nz, div_ovf;
  logic [31:0] dvs_s, dvs_u, quo_s, rem_s, quo_u, rem_u;

  assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Divisor forced to 1 for B=0 and for INT_MIN/-1; the latter then yields exactly LO=INT_MIN, HI=0.
  assign b_nz    = (B != 32'd0);
  assign div_ovf = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
  assign dvs_s   = (b_nz && !div_ovf) ? B : 32'd1;
  assign dvs_u   = b_nz ? B : 32'd1;
  assign quo_s   = $signed(A) / $signed(dvs_s);
  assign rem_s   = $signed(A) % $signed(dvs_s);
  assign quo_u   = A / dvs_u;
  assign rem_u   = A % dvs_u;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    thi_d    = thi_q;
    tlo_d    = tlo_q;
    commit_d = commit_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (MDUOp)
            4'd1: begin
              {thi_d, tlo_d} = prod_s;
              cnt_d          = CW'(MULT_CYCLES);
              commit_d       = 1'b1;
              state_d        = S_RUN;
            end
            4'd2: begin
              {thi_d, tlo_d} = prod_u;
              cnt_d          = CW'(MULT_CYCLES);
              commit_d       = 1'b1;
              state_d        = S_RUN;
            end
            4'd3: begin
              thi_d    = rem_s;
              tlo_d    = quo_s;
              cnt_d    = CW'(DIV_CYCLES);
              commit_d = b_nz;
              state_d  = S_RUN;
            end
            4'd4: begin
              thi_d    = rem_u;
              tlo_d    = quo_u;
              cnt_d    = CW'(DIV_CYCLES);
              commit_d = b_nz;
              state_d  = S_RUN;
            end
            4'd5:    hi_d = A;
            4'd6:    lo_d = A;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_IDLE;
          if (commit_q) begin
            hi_d = thi_q;
            lo_d = tlo_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      thi_q    <= '0;
      tlo_q    <= '0;
      commit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      thi_q    <= thi_d;
      tlo_q    <= tlo_d;
      commit_q <= commit_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

  always_comb begin
    case (MDUOp)
      4'd7:    MDUOut = hi_q;
      4'd8:    MDUOut = lo_q;
      default: MDUOut = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: busy length, HI/LO results, MTHI/MTLO, ignored starts and mid-run reset.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [3:0]  MDUOp;
  logic [31:0] A, B;
  logic        busy;
  logic [31:0] HI, LO, MDUOut;

  int ntests = 0;
  int nfail  = 0;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .MDUOp(MDUOp), .A(A), .B(B),
    .busy(busy), .HI(HI), .LO(LO), .MDUOut(MDUOut)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles with busy high, starting in the cycle right after the start edge.
  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 30) begin
      n++;
      tick();
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_cyc,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    start = 1'b1; MDUOp = op; A = a; B = b;
    tick();
    start = 1'b0; MDUOp = 4'd0; A = 32'd0; B = 32'd0;
    count_busy(n);
    check({tag, "_cycles"}, 32'(n), 32'(exp_cyc));
    check({tag, "_hi"}, HI, exp_hi);
    check({tag, "_lo"}, LO, exp_lo);
  endtask

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; MDUOp = 4'd0; A = 32'd0; B = 32'd0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);

    run_op("mult_neg", 4'd1, 32'hFFFF_FFFD, 32'd5, 5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("multu", 4'd2, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE);

    MDUOp = 4'd7; #1;
    check("mfhi", MDUOut, 32'h0000_0001);
    MDUOp = 4'd8; #1;
    check("mflo", MDUOut, 32'hFFFF_FFFE);
    MDUOp = 4'd3; #1;
    check("mdu_out_other", MDUOut, 32'd0);
    MDUOp = 4'd0;

    run_op("div_neg", 4'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_zero", 4'd4, 32'd7, 32'd0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_negdvs", 4'd3, 32'd7, 32'hFFFF_FFFE, 10, 32'd1, 32'hFFFF_FFFD);
    run_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);
    run_op("divu", 4'd4, 32'd100, 32'd7, 10, 32'd2, 32'd14);

    // Second start during RUN must be ignored.
    start = 1'b1; MDUOp = 4'd1; A = 32'd2; B = 32'd3;
    tick();
    start = 1'b0; MDUOp = 4'd0;
    check("ign_busy_c1", {31'd0, busy}, 32'd1);
    tick();
    start = 1'b1; MDUOp = 4'd4; A = 32'd100; B = 32'd7;
    tick();
    start = 1'b0; MDUOp = 4'd0; A = 32'd0; B = 32'd0;
    count_busy(n);
    check("ign_cycles", 32'(n + 2), 32'd5);
    check("ign_hi", HI, 32'd0);
    check("ign_lo", LO, 32'd6);
    repeat (12) tick();
    check("ign_late_busy", {31'd0, busy}, 32'd0);
    check("ign_late_lo", LO, 32'd6);

    // MTHI then MTLO on back-to-back cycles.
    start = 1'b1; MDUOp = 4'd5; A = 32'h1234_5678;
    tick();
    check("mthi_busy", {31'd0, busy}, 32'd0);
    MDUOp = 4'd6; A = 32'h9ABC_DEF0;
    tick();
    check("mtlo_busy", {31'd0, busy}, 32'd0);
    start = 1'b0; MDUOp = 4'd0; A = 32'd0;
    check("mthi_hi", HI, 32'h1234_5678);
    check("mtlo_lo", LO, 32'h9ABC_DEF0);

    // Start with a non-executing op code changes nothing.
    start = 1'b1; MDUOp = 4'd7; A = 32'hDEAD_BEEF;
    tick();
    MDUOp = 4'd12;
    tick();
    start = 1'b0; MDUOp = 4'd0; A = 32'd0;
    check("nop_busy", {31'd0, busy}, 32'd0);
    check("nop_hi", HI, 32'h1234_5678);
    check("nop_lo", LO, 32'h9ABC_DEF0);

    // Reset in cycle 4 of a DIV cancels it.
    start = 1'b1; MDUOp = 4'd3; A = 32'd100; B = 32'd7;
    tick();
    start = 1'b0; MDUOp = 4'd0;
    repeat (3) tick();
    check("rstrun_busy_pre", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstrun_busy", {31'd0, busy}, 32'd0);
    check("rstrun_hi", HI, 32'd0);
    check("rstrun_lo", LO, 32'd0);
    repeat (12) tick();
    check("rstrun_late_busy", {31'd0, busy}, 32'd0);
    check("rstrun_late_hi", HI, 32'd0);
    check("rstrun_late_lo", LO, 32'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
